// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers: state encoding,
// per-boundary bundle widths and the NOP bundles used as bubble values.
package pipe_pkg;

  typedef logic [1:0] stage_state_t;

  // State bits are {skid_v, main_v}
  localparam stage_state_t ST_EMPTY = 2'b00;
  localparam stage_state_t ST_FULL  = 2'b01;
  localparam stage_state_t ST_SKID  = 2'b11;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 148;
  localparam int EX_MEM_W = 75;
  localparam int MEM_WB_W = 71;

  // IF/ID bubble carries the canonical addi x0,x0,0 so decode sees a real NOP.
  localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = {32'h0000_0013, 32'h0000_0000};
  localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = '0;
  localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;
  localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = '0;

  function automatic logic [1:0] occupancy_of(stage_state_t st);
    case (st)
      ST_FULL: occupancy_of = 2'd1;
      ST_SKID: occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module pipe_stage_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (en && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush and bubble value.
// Optional statistics counters are enabled with PIPE_STAGE_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = EX_MEM_W,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  stage_state_t     state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
      main_reg  <= RESET_VAL;
      skid_reg  <= RESET_VAL;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  // The main register is reloaded with RESET_VAL whenever the stage empties,
  // so out_data can be driven straight from it without a mux.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (in_valid) begin
          state_next = ST_FULL;
          main_next  = in_data;
        end
      end
      ST_FULL: begin
        if (in_valid && out_ready) begin
          main_next = in_data;
        end else if (in_valid) begin
          state_next = ST_SKID;
          skid_next  = in_data;
        end else if (out_ready) begin
          state_next = ST_EMPTY;
          main_next  = RESET_VAL;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          state_next = ST_FULL;
          main_next  = skid_reg;
          skid_next  = RESET_VAL;
        end
      end
      default: begin
        state_next = ST_EMPTY;
        main_next  = RESET_VAL;
        skid_next  = RESET_VAL;
      end
    endcase
    if (flush) begin
      state_next = ST_EMPTY;
      main_next  = RESET_VAL;
      skid_next  = RESET_VAL;
    end
  end

  // in_ready is the inverted skid-valid flop: no path from out_ready.
  always_comb begin
    in_ready  = ~state_reg[1];
    out_valid = state_reg[0];
    out_data  = main_reg;
    occupancy = occupancy_of(state_reg);
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_sat_cnt #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_stage_sat_cnt #(.WIDTH(16)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush & (occupancy != 2'd0)),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, statistics
// sequences (when PIPE_STAGE_STATS_EN is defined) and a randomized queue model.
module tb_pipe_stage_skid;

  localparam int W = 75;
  localparam logic [W-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]  stall_cnt;
  logic [15:0]  flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    logic         rst;
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         eov;
    logic [W-1:0] eod;
    logic         eir;
    logic [1:0]   eocc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [W-1:0] d,
                     input logic ordy, input logic eov, input logic [W-1:0] eod,
                     input logic eir, input logic [1:0] eocc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eir = eir; v.eocc = eocc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and return 1 ns after the edge.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the stage is a FIFO of depth 2 whose head is out_data.
  logic [W-1:0] mq[$];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //  rst fl iv  data      ordy  ov  out_data  ir occ
    add(1, 0, 1, 75'h5A5, 0,   0, 75'h0,  1, 2'd0);
    add(1, 0, 1, 75'h5A5, 0,   0, 75'h0,  1, 2'd0);
    add(0, 0, 1, 75'h1,   1,   1, 75'h1,  1, 2'd1);
    add(0, 0, 1, 75'h2,   1,   1, 75'h2,  1, 2'd1);
    add(0, 0, 1, 75'h3,   1,   1, 75'h3,  1, 2'd1);
    add(0, 0, 1, 75'h4,   1,   1, 75'h4,  1, 2'd1);
    add(0, 0, 0, 75'h0,   1,   0, 75'h0,  1, 2'd0);
    add(0, 0, 1, 75'h11,  0,   1, 75'h11, 1, 2'd1);
    add(0, 0, 1, 75'h22,  0,   1, 75'h11, 0, 2'd2);
    add(0, 0, 1, 75'h33,  0,   1, 75'h11, 0, 2'd2);
    add(0, 0, 1, 75'h33,  1,   1, 75'h22, 1, 2'd1);
    add(0, 0, 1, 75'h33,  1,   1, 75'h33, 1, 2'd1);
    add(0, 0, 0, 75'h0,   1,   0, 75'h0,  1, 2'd0);
    add(0, 0, 1, 75'h55,  0,   1, 75'h55, 1, 2'd1);
    add(0, 0, 1, 75'h66,  0,   1, 75'h55, 0, 2'd2);
    add(0, 1, 1, 75'h44,  0,   0, 75'h0,  1, 2'd0);
    add(0, 0, 0, 75'h0,   1,   0, 75'h0,  1, 2'd0);
    add(0, 0, 1, 75'h77,  0,   1, 75'h77, 1, 2'd1);
    add(1, 1, 1, 75'h88,  1,   0, 75'h0,  1, 2'd0);
    add(0, 0, 1, 75'h99,  0,   1, 75'h99, 1, 2'd1);
    add(0, 1, 1, 75'hAA,  1,   0, 75'h0,  1, 2'd0);
    add(0, 0, 0, 75'h0,   0,   0, 75'h0,  1, 2'd0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].fl, vq[i].iv, vq[i].d, vq[i].ordy);
      $display("vec %0d: rst=%b fl=%b iv=%b d=%h ordy=%b -> ov=%b od=%h ir=%b occ=%0d",
               i, vq[i].rst, vq[i].fl, vq[i].iv, vq[i].d, vq[i].ordy,
               out_valid, out_data, in_ready, occupancy);
      chk($sformatf("vec%0d out_valid", i), W'(out_valid), W'(vq[i].eov));
      chk($sformatf("vec%0d out_data", i),  out_data,       vq[i].eod);
      chk($sformatf("vec%0d in_ready", i),  W'(in_ready),   W'(vq[i].eir));
      chk($sformatf("vec%0d occupancy", i), W'(occupancy),  W'(vq[i].eocc));
    end

`ifdef PIPE_STAGE_STATS_EN
    step(1, 0, 0, '0, 0);
    chk("stats stall after reset", W'(stall_cnt), W'(0));
    chk("stats flush after reset", W'(flush_cnt), W'(0));
    step(0, 0, 1, 75'h1, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, '0, 0);
    $display("stats: stall_cnt=%0d after 5 stalled cycles", stall_cnt);
    chk("stall_cnt 5", W'(stall_cnt), W'(5));
    force dut.u_stall_cnt.count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.count_reg;
    step(0, 0, 0, '0, 0);
    chk("stall_cnt saturated", W'(stall_cnt), W'(32'hFFFF_FFFF));
    step(0, 1, 0, '0, 0);
    chk("flush_cnt counts held", W'(flush_cnt), W'(1));
    step(0, 1, 0, '0, 0);
    chk("flush_cnt ignores empty", W'(flush_cnt), W'(1));
    step(0, 0, 1, 75'h5, 0);
    step(1, 1, 0, '0, 0);
    $display("stats: reset+flush -> occ=%0d flush_cnt=%0d", occupancy, flush_cnt);
    chk("reset+flush occupancy", W'(occupancy), W'(0));
    chk("flush_cnt cleared", W'(flush_cnt), W'(0));
    chk("stall_cnt cleared", W'(stall_cnt), W'(0));
`endif

    step(1, 0, 0, '0, 0);
    mq.delete();
    for (int n = 0; n < 400; n++) begin
      logic         r_rst, r_fl, r_iv, r_or;
      logic [95:0]  r_raw;
      logic [W-1:0] r_d;
      logic         e_ov, e_ir;
      logic [W-1:0] e_od;

      e_ov = (mq.size() > 0);
      e_ir = (mq.size() < 2);
      e_od = e_ov ? mq[0] : RV;
      chk("rnd out_valid", W'(out_valid), W'(e_ov));
      chk("rnd out_data",  out_data,       e_od);
      chk("rnd in_ready",  W'(in_ready),   W'(e_ir));
      chk("rnd occupancy", W'(occupancy),  W'(mq.size()));

      r_rst = ($urandom_range(0, 99) < 2);
      r_fl  = ($urandom_range(0, 99) < 5);
      r_iv  = ($urandom_range(0, 99) < 70);
      r_or  = ($urandom_range(0, 99) < 60);
      r_raw = {$urandom(), $urandom(), $urandom()};
      r_d   = r_raw[W-1:0];

      if (e_ov && r_or && !r_rst)
        $display("rnd %0d: out transfer data=%h", n, e_od);
      if (r_rst || r_fl) begin
        mq.delete();
      end else begin
        if (e_ov && r_or) void'(mq.pop_front());
        if (r_iv && e_ir) mq.push_back(r_d);
      end
      step(r_rst, r_fl, r_iv, r_d, r_or);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
